fix2flt_conv: RTL

Converts a signed 8.8 fixed-point value in data memory to IEEE-754 half precision, normalising one bit per cycle. It is the sibling stage of the float-to-fixed converter and sits on the same data-memory port and start/done test-bench handshake. The block reads two bytes at `IN_ADDR`/`IN_ADDR+1`, writes the half-precision result to `OUT_ADDR`/`OUT_ADDR+1`, then pulses `done`.

---
 rtl/fix2flt_conv_if.sv | 31 +++
 rtl/fix2flt_conv.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fix2flt_conv_if.sv
// Start/done handshake plus data-memory port shared by the fixed/float converter stages.
// The converter connects through the master modport. The bench/memory side connects through the slave modport.
interface fix2flt_conv_if;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;

    modport master (
        input  start,
        input  dm_rdata,
        output done,
        output busy,
        output dm_addr,
        output dm_wr_en,
        output dm_wdata
    );

    modport slave (
        output start,
        output dm_rdata,
        input  done,
        input  busy,
        input  dm_addr,
        input  dm_wr_en,
        input  dm_wdata
    );
endinterface

// File: rtl/fix2flt_conv.sv
// fix2flt_conv: signed 8.8 fixed point in data memory -> IEEE-754 half precision.
// The block reads two bytes, normalises the value one bit per clock, and rounds or truncates the result.
// It writes the result as two bytes and then pulses done.
// Optional feature macro: FIX2FLT_ROUND_EN.
//   - Defined: the result rounds to nearest even.
//   - Undefined: the result truncates.
//   - Latency is the same in both builds.
module fix2flt_conv #(
    parameter logic [7:0] IN_ADDR  = 8'd0,
    parameter logic [7:0] OUT_ADDR = 8'd2
) (
    input  logic           clk,
    input  logic           reset,
    fix2flt_conv_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAP,
        NORM,
        ROUND,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        start_q_reg;
    logic [7:0]  lo_reg, lo_next;
    logic        sign_reg, sign_next;
    logic [15:0] mag_reg, mag_next;
    logic [4:0]  exp_reg, exp_next;
    logic [15:0] result_reg, result_next;

    // Helper terms used by the CAP and ROUND states.
    logic [15:0] x_in;
    logic [15:0] x_mag;
    logic [9:0]  frac;
    logic        round_inc;
    logic [10:0] frac_sum;

    assign x_in  = {bus.dm_rdata, lo_reg};
    // 0x8000 negates to itself, which is the correct magnitude when read as unsigned.
    assign x_mag = x_in[15] ? (~x_in + 16'd1) : x_in;
    assign frac  = mag_reg[14:5];

`ifdef FIX2FLT_ROUND_EN
    logic guard;
    logic sticky;
    assign guard     = mag_reg[4];
    assign sticky    = |mag_reg[3:0];
    assign round_inc = guard & (sticky | frac[0]);
`else
    assign round_inc = 1'b0;
`endif

    assign frac_sum = {1'b0, frac} + {10'd0, round_inc};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            start_q_reg <= 1'b0;
            lo_reg      <= 8'd0;
            sign_reg    <= 1'b0;
            mag_reg     <= 16'd0;
            exp_reg     <= 5'd0;
            result_reg  <= 16'd0;
        end else begin
            state_reg   <= state_next;
            start_q_reg <= bus.start;
            lo_reg      <= lo_next;
            sign_reg    <= sign_next;
            mag_reg     <= mag_next;
            exp_reg     <= exp_next;
            result_reg  <= result_next;
        end
    end

    // Next-state logic and datapath updates. Memory and handshake outputs decode from the state alone.
    always_comb begin
        state_next   = state_reg;
        lo_next      = lo_reg;
        sign_next    = sign_reg;
        mag_next     = mag_reg;
        exp_next     = exp_reg;
        result_next  = result_reg;
        bus.dm_addr  = 8'd0;
        bus.dm_wr_en = 1'b0;
        bus.dm_wdata = 8'd0;
        bus.done     = 1'b0;
        bus.busy     = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                // A falling edge of start triggers a conversion. It only counts while idle.
                if (start_q_reg && !bus.start) begin
                    state_next = RD_LO;
                end
            end
            RD_LO: begin
                bus.dm_addr = IN_ADDR;
                state_next  = RD_HI;
            end
            RD_HI: begin
                bus.dm_addr = IN_ADDR + 8'd1;
                lo_next     = bus.dm_rdata;
                state_next  = CAP;
            end
            CAP: begin
                sign_next = x_in[15];
                mag_next  = x_mag;
                if (x_in == 16'd0) begin
                    result_next = 16'd0;
                    state_next  = WR_LO;
                end else begin
                    exp_next   = 5'd22;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mag_reg[15]) begin
                    state_next = ROUND;
                end else begin
                    mag_next = {mag_reg[14:0], 1'b0};
                    exp_next = exp_reg - 5'd1;
                end
            end
            ROUND: begin
                // A mantissa carry-out wraps frac to zero and bumps the exponent.
                if (frac_sum[10]) begin
                    result_next = {sign_reg, exp_reg + 5'd1, 10'd0};
                end else begin
                    result_next = {sign_reg, exp_reg, frac_sum[9:0]};
                end
                state_next = WR_LO;
            end
            WR_LO: begin
                bus.dm_wr_en = 1'b1;
                bus.dm_addr  = OUT_ADDR;
                bus.dm_wdata = result_reg[7:0];
                state_next   = WR_HI;
            end
            WR_HI: begin
                bus.dm_wr_en = 1'b1;
                bus.dm_addr  = OUT_ADDR + 8'd1;
                bus.dm_wdata = result_reg[15:8];
                state_next   = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
